syscall_unit: RTL

Executes MIPS `syscall` services for the pipelined CPU: print integer, print character and exit. It takes the decode-stage syscall request and the already-forwarded `$v0`/`$a0` values. It streams ASCII bytes to a console sink over a valid/ready handshake. It raises `busy` back to the hazard unit, which holds fetch/decode stalled until the service completes.

---
 rtl/syscall_unit.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/syscall_unit.sv
// -----------------------------------------------------------------------------
// syscall_unit
//
// Runs the MIPS syscall services (print integer, print character, exit) for the
// pipelined CPU. The decode stage presents the request together with the
// already-forwarded $v0/$a0 values. ASCII output is streamed to a console sink
// over a valid/ready handshake. While a service is running, busy stalls
// fetch/decode.
//
// Optional feature: define SYSCALL_HEX_EN to add service 34 (print hex).
// That service prints "0x" followed by 8 lowercase hex digits.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   sig_syscall_d  decode stage holds a syscall
//   stall_d        decode stalled for another hazard; blocks accept
//   v0_val         forwarded $v0 (service number)
//   a0_val         forwarded $a0 (argument)
//   busy           stall request to the hazard unit
//   out_valid      out_data holds a byte for the sink
//   out_data       ASCII byte
//   out_ready      sink accepts the byte
//   halted         sticky, set by the exit service
//   bad_svc        one-cycle pulse for an unsupported service number
// -----------------------------------------------------------------------------
module syscall_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_syscall_d,
    input  logic        stall_d,
    input  logic [31:0] v0_val,
    input  logic [31:0] a0_val,
    output logic        busy,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halted,
    output logic        bad_svc
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SIGN  = 3'd1,
        S_DIGIT = 3'd2,
        S_EMIT  = 3'd3,
        S_CHAR  = 3'd4,
        S_HALT  = 3'd5
`ifdef SYSCALL_HEX_EN
        , S_HEX = 3'd6
`endif
    } state_t;

    // Print-char only needs the low byte of the argument.
    // Print-hex needs the whole word.
`ifdef SYSCALL_HEX_EN
    localparam int ARG_W = 32;
`else
    localparam int ARG_W = 8;
`endif

    state_t             state_q, state_d;
    logic [ARG_W-1:0]   arg_q, arg_d;
    logic [31:0]        mag_q, mag_d;
    logic [3:0]         k_q, k_d;
    logic [3:0]         digit_q, digit_d;
    logic               started_q, started_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               halted_q, halted_d;
    logic               bad_svc_q, bad_svc_d;
`ifdef SYSCALL_HEX_EN
    logic [3:0]         hex_idx_q, hex_idx_d;
`endif

    logic               accept;
    logic               xfer;
    logic [31:0]        pow;

    // Decimal place values. The digit loop subtracts these from the magnitude.
    function automatic logic [31:0] pow10(input logic [3:0] k);
        logic [31:0] p;
        case (k)
            4'd0:    p = 32'd1;
            4'd1:    p = 32'd10;
            4'd2:    p = 32'd100;
            4'd3:    p = 32'd1000;
            4'd4:    p = 32'd10000;
            4'd5:    p = 32'd100000;
            4'd6:    p = 32'd1000000;
            4'd7:    p = 32'd10000000;
            4'd8:    p = 32'd100000000;
            4'd9:    p = 32'd1000000000;
            default: p = 32'd1;
        endcase
        return p;
    endfunction

`ifdef SYSCALL_HEX_EN
    // Byte number idx of "0x%08x".
    // Index 0 is '0', index 1 is 'x', indices 2..9 are the nibbles MSB first.
    function automatic logic [7:0] hex_char(input logic [31:0] a, input logic [3:0] idx);
        logic [3:0] nib;
        logic [7:0] c;
        case (idx)
            4'd2:    nib = a[31:28];
            4'd3:    nib = a[27:24];
            4'd4:    nib = a[23:20];
            4'd5:    nib = a[19:16];
            4'd6:    nib = a[15:12];
            4'd7:    nib = a[11:8];
            4'd8:    nib = a[7:4];
            default: nib = a[3:0];
        endcase
        if (idx == 4'd0)
            c = 8'h30;
        else if (idx == 4'd1)
            c = 8'h78;
        else if (nib < 4'd10)
            c = 8'h30 + {4'h0, nib};
        else
            c = 8'h57 + {4'h0, nib};    // 'a' - 10
        return c;
    endfunction
`endif

    assign accept = sig_syscall_d && !stall_d && (state_q == S_IDLE) && !halted_q;
    assign xfer   = out_valid_q && out_ready;
    assign pow    = pow10(k_q);

    always_comb begin
        state_d     = state_q;
        arg_d       = arg_q;
        mag_d       = mag_q;
        k_d         = k_q;
        digit_d     = digit_q;
        started_d   = started_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        halted_d    = halted_q;
        bad_svc_d   = 1'b0;
`ifdef SYSCALL_HEX_EN
        hex_idx_d   = hex_idx_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    arg_d = a0_val[ARG_W-1:0];
                    case (v0_val)
                        32'd1: begin
                            // The magnitude is computed here so that SIGN only
                            // has to wait for the '-' byte, if there is one.
                            // 0 - 0x80000000 wraps to 0x80000000, which is
                            // the correct unsigned magnitude.
                            state_d   = S_SIGN;
                            mag_d     = a0_val[31] ? (32'd0 - a0_val) : a0_val;
                            k_d       = 4'd9;
                            digit_d   = 4'd0;
                            started_d = 1'b0;
                            if (a0_val[31]) begin
                                out_valid_d = 1'b1;
                                out_data_d  = 8'h2D;
                            end
                        end
                        32'd11: begin
                            state_d     = S_CHAR;
                            out_valid_d = 1'b1;
                            out_data_d  = a0_val[7:0];
                        end
                        32'd10: begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
`ifdef SYSCALL_HEX_EN
                        32'd34: begin
                            state_d     = S_HEX;
                            out_valid_d = 1'b1;
                            out_data_d  = 8'h30;
                            hex_idx_d   = 4'd0;
                        end
`endif
                        default: bad_svc_d = 1'b1;
                    endcase
                end
            end

            S_SIGN: begin
                // If the '-' byte is pending, hold until it is taken.
                if (!out_valid_q || xfer) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DIGIT;
                end
            end

            S_DIGIT: begin
                if (mag_q >= pow) begin
                    mag_d   = mag_q - pow;
                    digit_d = digit_q + 4'd1;
                end else if ((digit_q != 4'd0) || started_q || (k_q == 4'd0)) begin
                    // Leading zeros are skipped until the first non-zero digit.
                    // After that, interior zeros are printed.
                    // The units digit is always printed.
                    state_d     = S_EMIT;
                    out_valid_d = 1'b1;
                    out_data_d  = 8'h30 + {4'h0, digit_q};
                    started_d   = 1'b1;
                end else begin
                    k_d = k_q - 4'd1;
                end
            end

            S_EMIT: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    if (k_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        k_d     = k_q - 4'd1;
                        digit_d = 4'd0;
                        state_d = S_DIGIT;
                    end
                end
            end

            S_CHAR: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

`ifdef SYSCALL_HEX_EN
            S_HEX: begin
                if (xfer) begin
                    if (hex_idx_q == 4'd9) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        hex_idx_d  = hex_idx_q + 4'd1;
                        out_data_d = hex_char(arg_q, hex_idx_q + 4'd1);
                    end
                end
            end
`endif

            S_HALT: begin
                // Absorbing; only reset leaves.
            end

            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            arg_q       <= '0;
            mag_q       <= 32'd0;
            k_q         <= 4'd0;
            digit_q     <= 4'd0;
            started_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            halted_q    <= 1'b0;
            bad_svc_q   <= 1'b0;
`ifdef SYSCALL_HEX_EN
            hex_idx_q   <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            arg_q       <= arg_d;
            mag_q       <= mag_d;
            k_q         <= k_d;
            digit_q     <= digit_d;
            started_q   <= started_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            halted_q    <= halted_d;
            bad_svc_q   <= bad_svc_d;
`ifdef SYSCALL_HEX_EN
            hex_idx_q   <= hex_idx_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE) || halted_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign halted    = halted_q;
    assign bad_svc   = bad_svc_q;

endmodule
